alu_req_sequencer: RTL

Sequencer and arbiter that shares one combinational 8-bit ALU between two requesters. The ALU computes add, subtract, compare or square, and its output Y is 2N bits wide. The block does four things:
- takes operations over valid/ready handshakes;
- arbitrates round-robin between the requesters;
- registers the operands into the ALU and waits a programmable number of settle cycles;
- captures the result and returns it on a per-requester response handshake.

It sits between the requesting masters and the shared ALU instance, which is wired to the alu_* ports.

---
 rtl/alu_req_sequencer_pkg.sv | 16 +
 rtl/alu_req_sequencer_arb.sv | 15 +
 rtl/alu_req_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_req_sequencer_pkg.sv
// Shared definitions for the two-requester ALU sequencer: FSM state
// encoding and the ALU op-select codes.
package alu_req_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_SQR = 2'b11;

endpackage

// File: rtl/alu_req_sequencer_arb.sv
// Combinational 2-way round-robin arbiter. A lone requester always wins;
// under contention the requester that was not served last wins.
module rr_arbiter_2
    import alu_req_sequencer_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       rr_last,
    output logic       grant_id,
    output logic       grant_any
);

    assign grant_any = |req_valid;
    assign grant_id  = (&req_valid) ? ~rr_last : req_valid[1];

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one external combinational ALU between two requesters: accepts an
// op, drives registered operands to the ALU, waits the settle time, then
// returns the captured result on the winner's response handshake.
module alu_req_sequencer
    import alu_req_sequencer_pkg::*;
#(
    parameter int N        = 8,
    parameter int ADD_WAIT = 0,
    parameter int SQR_WAIT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [1:0]     req_cin,
    input  logic [1:0]     req_bin,
    input  logic [3:0]     req_sel,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [2*N-1:0] rsp_y,
    output logic           rsp_cout,
    output logic           rsp_bout,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic           alu_cin,
    output logic           alu_bin,
    output logic [1:0]     alu_sel,
    input  logic [2*N-1:0] alu_y,
    input  logic           alu_cout,
    input  logic           alu_bout,
    output logic           busy
);

    localparam int MAX_WAIT = (ADD_WAIT > SQR_WAIT) ? ADD_WAIT : SQR_WAIT;
    localparam int WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_t         state;
    logic           g_q;
    logic           rr_last;
    logic [WCW-1:0] wait_cnt;

    logic           grant_id;
    logic           grant_any;
    logic [N-1:0]   win_a;
    logic [N-1:0]   win_b;
    logic           win_cin;
    logic           win_bin;
    logic [1:0]     win_sel;

    rr_arbiter_2 u_arb (
        .req_valid (req_valid),
        .rr_last   (rr_last),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Operand fields of whichever requester the arbiter picked.
    assign win_a   = grant_id ? req_a[2*N-1:N] : req_a[N-1:0];
    assign win_b   = grant_id ? req_b[2*N-1:N] : req_b[N-1:0];
    assign win_cin = req_cin[grant_id];
    assign win_bin = req_bin[grant_id];
    assign win_sel = grant_id ? req_sel[3:2] : req_sel[1:0];

    // NOTE: req_ready is gated by rst so every output reads 0 while reset is held.
    assign req_ready = (state == IDLE && grant_any && !rst)
                     ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

    // Accept / settle / respond FSM with operand, counter and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g_q       <= 1'b0;
            rr_last   <= 1'b1;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_bin   <= 1'b0;
            alu_sel   <= 2'b00;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_bout  <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a    <= win_a;
                        alu_b    <= win_b;
                        alu_cin  <= win_cin;
                        alu_bin  <= win_bin;
                        alu_sel  <= win_sel;
                        g_q      <= grant_id;
                        wait_cnt <= (win_sel == OP_SQR) ? WCW'(SQR_WAIT) : WCW'(ADD_WAIT);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (wait_cnt == '0) begin
                        rsp_y     <= alu_y;
                        rsp_cout  <= alu_cout;
                        rsp_bout  <= alu_bout;
                        rsp_valid <= g_q ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[g_q]) begin
                        rsp_valid <= 2'b00;
                        rr_last   <= g_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
